// File: rtl/counter_pkg.sv
// Shared constants for the programmable-modulus counter family.
package counter_pkg;

  localparam int DEF_WIDTH      = 6;
  localparam int DEF_PRESCALE_W = 4;

  // up_dn encoding
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // sat_mode encoding
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/mod_prescaler.sv
// Clock-enable prescaler: one tick every prescale+1 enabled cycles.
module mod_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt;

  // >= rather than == so a prescale shrunk mid-period below pre_cnt
  // still fires on the next enabled cycle instead of running to rollover.
  assign tick = en && (pre_cnt >= prescale);

  // Period counter; restart realigns the period with a clear or load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pre_cnt <= '0;
    else if (restart) pre_cnt <= '0;
    else if (en)      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

endmodule

// File: rtl/mod_counter_gen.sv
// Programmable-modulus up/down counter with wrap/saturate boundary handling,
// prescaled stepping, terminal-count pulse and sticky wrap flag.
module mod_counter_gen
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int RST_MAX    = 54
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_val,
  input  logic                  up_dn,
  input  logic                  sat_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  wrapped
);

  // RST_MAX only documents the usual modulus; reject one that cannot fit.
  if (RST_MAX < 0 || RST_MAX > (2**WIDTH) - 1) begin : g_bad_rst_max
    $error("RST_MAX does not fit in WIDTH bits");
  end

  logic             tick;
  logic [WIDTH-1:0] nxt_count;
  logic             nxt_tc;
  logic             nxt_wrap;

  mod_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (clr | load),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next count for a tick; the >= / > compares absorb a loaded value above max_val.
  always_comb begin
    nxt_count = count;
    nxt_tc    = 1'b0;
    nxt_wrap  = 1'b0;
    if (up_dn == DIR_UP) begin
      if (count < max_val) begin
        nxt_count = count + 1'b1;
      end else begin
        nxt_tc = 1'b1;
        if (sat_mode == MODE_SAT) begin
          nxt_count = max_val;
        end else begin
          nxt_count = '0;
          nxt_wrap  = 1'b1;
        end
      end
    end else begin
      if (count == '0) begin
        nxt_tc = 1'b1;
        if (sat_mode == MODE_WRAP) begin
          nxt_count = max_val;
          nxt_wrap  = 1'b1;
        end
      end else if (count > max_val) begin
        nxt_count = max_val;
      end else begin
        nxt_count = count - 1'b1;
      end
    end
  end

  // Count / tc / wrapped state with clr > load > step priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      tc      <= 1'b0;
    end else if (tick) begin
      count   <= nxt_count;
      tc      <= nxt_tc;
      wrapped <= wrapped | nxt_wrap;
    end else begin
      tc      <= 1'b0;
    end
  end

  assign at_max  = (count == max_val);
  assign at_zero = (count == '0);

endmodule
